// File: rtl/bus_datapath_if.sv
// rtl/bus_datapath_if.sv - memory req/ack port bundle between bus_datapath and external memory
interface bus_datapath_if #(
  parameter int WIDTH = 32,
  parameter int AW    = 9
);
  logic             mem_req;
  logic             mem_we;
  logic [AW-1:0]    mem_addr;
  logic [WIDTH-1:0] mem_wdata;
  logic [WIDTH-1:0] mem_rdata;
  logic             mem_ack;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_rdata, mem_ack
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_rdata, mem_ack
  );
endinterface

// File: rtl/bus_datapath.sv
// rtl/bus_datapath.sv - parametrised single-bus CPU datapath with req/ack memory port
// Define BUS_DATAPATH_MULDIV_EN to build the iterative signed MUL/DIV unit.
module bus_datapath #(
  parameter int               WIDTH    = 32,
  parameter int               NREGS    = 16,
  parameter logic [WIDTH-1:0] PC_RESET = '0,
  parameter int               AW       = 9
) (
  input  logic                     clock,
  input  logic                     clear,
  input  logic [3:0]               bus_src,
  input  logic [$clog2(NREGS)-1:0] reg_rsel,
  input  logic [$clog2(NREGS)-1:0] reg_wsel,
  input  logic                     reg_we,
  input  logic                     y_in,
  input  logic                     hi_in,
  input  logic                     lo_in,
  input  logic                     mar_in,
  input  logic                     ir_in,
  input  logic                     out_in,
  input  logic                     mdr_in,
  input  logic                     pc_in,
  input  logic                     inc_pc,
  input  logic                     z_in,
  input  logic                     con_in,
  input  logic [4:0]               alu_op,
  input  logic                     alu_start,
  output logic                     alu_busy,
  output logic                     alu_done,
  input  logic                     mem_read,
  input  logic                     mem_write,
  bus_datapath_if.master           mem,
  input  logic [WIDTH-1:0]         inport_data,
  input  logic                     inport_strobe,
  output logic [WIDTH-1:0]         outport_data,
  output logic [WIDTH-1:0]         ir_out,
  output logic                     con_out,
  output logic [WIDTH-1:0]         bus_out
);
  localparam int SW = $clog2(WIDTH);

  logic [WIDTH-1:0] regs_q [NREGS];
  logic [WIDTH-1:0] regs_d [NREGS];
  logic [WIDTH-1:0] y_q, hi_q, lo_q, pc_q, ir_q, mar_q, mdr_q, zhi_q, zlo_q, out_q, in_q;
  logic [WIDTH-1:0] y_d, hi_d, lo_d, pc_d, ir_d, mar_d, mdr_d, zhi_d, zlo_d, out_d, in_d;
  logic             con_q, con_d;
  logic [WIDTH-1:0] bus, c_sign, alu_res;
  logic [SW-1:0]    shamt;
  logic [2*WIDTH-1:0] rot_r, rot_l;
  logic             md_start, md_fin;
  logic [WIDTH-1:0] md_zhi, md_zlo;
  logic             rd_done;

  assign c_sign = {{(WIDTH-19){ir_q[18]}}, ir_q[18:0]};

  always_comb begin
    bus = '0;
    case (bus_src)
      4'd0:    bus = regs_q[reg_rsel];
      4'd1:    bus = mdr_q;
      4'd2:    bus = pc_q;
      4'd3:    bus = zhi_q;
      4'd4:    bus = zlo_q;
      4'd5:    bus = hi_q;
      4'd6:    bus = lo_q;
      4'd7:    bus = in_q;
      4'd8:    bus = c_sign;
      default: bus = '0;
    endcase
  end

  assign shamt = bus[SW-1:0];
  assign rot_r = {y_q, y_q} >> shamt;
  assign rot_l = {y_q, y_q} << shamt;

  always_comb begin
    alu_res = '0;
    case (alu_op)
      5'd0:    alu_res = y_q + bus;
      5'd1:    alu_res = y_q - bus;
      5'd2:    alu_res = y_q & bus;
      5'd3:    alu_res = y_q | bus;
      5'd4:    alu_res = y_q >> shamt;
      5'd5:    alu_res = $signed(y_q) >>> shamt;
      5'd6:    alu_res = y_q << shamt;
      5'd7:    alu_res = rot_r[WIDTH-1:0];
      5'd8:    alu_res = rot_l[2*WIDTH-1:WIDTH];
      5'd9:    alu_res = -bus;
      5'd10:   alu_res = ~bus;
      default: alu_res = '0;
    endcase
  end

  assign md_start = alu_start && (alu_op == 5'd11 || alu_op == 5'd12);

`ifdef BUS_DATAPATH_MULDIV_EN
  localparam int CW = $clog2(WIDTH);
  typedef enum logic [1:0] {A_IDLE, A_RUN, A_DONE} alu_state_t;

  alu_state_t         alu_state_q;
  logic               busy_q, done_q, md_div_q;
  logic [CW-1:0]      cnt_q;
  logic [WIDTH-1:0]   md_a_q, md_b_q, mag_a, mag_b;
  logic [2*WIDTH-1:0] acc_q, acc_step, mul_next, div_sh, div_next, prod;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH-1:0]   quot, rem;
  logic               neg_res;

  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v);
    return v[WIDTH-1] ? -v : v;
  endfunction

  assign mag_a  = magnitude(md_a_q);
  assign mag_b  = magnitude(md_b_q);
  assign md_fin = (alu_state_q == A_RUN) && (cnt_q == CW'(WIDTH - 1));

  // One shift-add (MUL) or restoring shift-subtract (DIV) step per cycle on magnitudes.
  always_comb begin
    mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, mag_a} : '0);
    mul_next = {mul_sum, acc_q[WIDTH-1:1]};
    div_sh   = {acc_q[2*WIDTH-2:0], 1'b0};
    div_next = div_sh;
    if (div_sh[2*WIDTH-1:WIDTH] >= mag_b) begin
      div_next[2*WIDTH-1:WIDTH] = div_sh[2*WIDTH-1:WIDTH] - mag_b;
      div_next[0]               = 1'b1;
    end
    acc_step = md_div_q ? div_next : mul_next;
    neg_res  = md_a_q[WIDTH-1] ^ md_b_q[WIDTH-1];
    prod     = neg_res ? -acc_step : acc_step;
    quot     = neg_res ? -acc_step[WIDTH-1:0] : acc_step[WIDTH-1:0];
    rem      = md_a_q[WIDTH-1] ? -acc_step[2*WIDTH-1:WIDTH] : acc_step[2*WIDTH-1:WIDTH];
    md_zhi   = prod[2*WIDTH-1:WIDTH];
    md_zlo   = prod[WIDTH-1:0];
    if (md_div_q) begin
      md_zhi = (md_b_q == '0) ? md_a_q : rem;
      md_zlo = (md_b_q == '0) ? '1 : quot;
    end
  end

  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      alu_state_q <= A_IDLE;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      md_div_q    <= 1'b0;
      cnt_q       <= '0;
      md_a_q      <= '0;
      md_b_q      <= '0;
      acc_q       <= '0;
    end else begin
      case (alu_state_q)
        A_IDLE: begin
          done_q <= 1'b0;
          if (md_start) begin
            alu_state_q <= A_RUN;
            busy_q      <= 1'b1;
            md_div_q    <= (alu_op == 5'd12);
            md_a_q      <= y_q;
            md_b_q      <= bus;
            cnt_q       <= '0;
            acc_q       <= {{WIDTH{1'b0}}, (alu_op == 5'd12) ? magnitude(y_q) : magnitude(bus)};
          end
        end
        A_RUN: begin
          acc_q <= acc_step;
          cnt_q <= cnt_q + 1'b1;
          if (md_fin) begin
            alu_state_q <= A_DONE;
            busy_q      <= 1'b0;
            done_q      <= 1'b1;
          end
        end
        A_DONE: begin
          alu_state_q <= A_IDLE;
          done_q      <= 1'b0;
        end
        default: begin
          alu_state_q <= A_IDLE;
          busy_q      <= 1'b0;
          done_q      <= 1'b0;
        end
      endcase
    end
  end

  assign alu_busy = busy_q;
  assign alu_done = done_q;
`else
  logic done_q;

  always_ff @(posedge clock or posedge clear) begin
    if (clear) done_q <= 1'b0;
    else       done_q <= md_start;
  end

  assign md_fin   = md_start;
  assign md_zhi   = '0;
  assign md_zlo   = '0;
  assign alu_busy = 1'b0;
  assign alu_done = done_q;
`endif

  typedef enum logic {M_IDLE, M_WAIT} mem_state_t;
  mem_state_t mem_state_q;
  logic       mem_req_q, mem_we_q;

  // A simultaneous read and write takes the read; new requests are ignored in WAIT.
  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      mem_state_q <= M_IDLE;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
    end else begin
      case (mem_state_q)
        M_IDLE: if (mem_read || mem_write) begin
          mem_state_q <= M_WAIT;
          mem_req_q   <= 1'b1;
          mem_we_q    <= !mem_read;
        end
        M_WAIT: if (mem.mem_ack) begin
          mem_state_q <= M_IDLE;
          mem_req_q   <= 1'b0;
          mem_we_q    <= 1'b0;
        end
        default: mem_state_q <= M_IDLE;
      endcase
    end
  end

  assign rd_done       = (mem_state_q == M_WAIT) && mem.mem_ack && !mem_we_q;
  assign mem.mem_req   = mem_req_q;
  assign mem.mem_we    = mem_we_q;
  assign mem.mem_addr  = mar_q[AW-1:0];
  assign mem.mem_wdata = mdr_q;

  always_comb begin
    regs_d = regs_q;
    if (reg_we) regs_d[reg_wsel] = bus;
    y_d   = y_in   ? bus : y_q;
    hi_d  = hi_in  ? bus : hi_q;
    lo_d  = lo_in  ? bus : lo_q;
    mar_d = mar_in ? bus : mar_q;
    ir_d  = ir_in  ? bus : ir_q;
    out_d = out_in ? bus : out_q;
    in_d  = inport_strobe ? inport_data : in_q;
    mdr_d = rd_done ? mem.mem_rdata : (mdr_in ? bus : mdr_q);
    pc_d  = pc_in ? bus : (inc_pc ? pc_q + WIDTH'(4) : pc_q);
    con_d = con_q;
    if (con_in) begin
      case (ir_q[20:19])
        2'b00:   con_d = (bus == '0);
        2'b01:   con_d = (bus != '0);
        2'b10:   con_d = !bus[WIDTH-1];
        default: con_d = bus[WIDTH-1];
      endcase
    end
    zhi_d = zhi_q;
    zlo_d = zlo_q;
    if (md_fin) begin
      zhi_d = md_zhi;
      zlo_d = md_zlo;
    end else if (z_in && !alu_busy) begin
      zhi_d = '0;
      zlo_d = alu_res;
    end
  end

  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
      y_q   <= '0;
      hi_q  <= '0;
      lo_q  <= '0;
      pc_q  <= PC_RESET;
      ir_q  <= '0;
      mar_q <= '0;
      mdr_q <= '0;
      zhi_q <= '0;
      zlo_q <= '0;
      out_q <= '0;
      in_q  <= '0;
      con_q <= 1'b0;
    end else begin
      regs_q <= regs_d;
      y_q    <= y_d;
      hi_q   <= hi_d;
      lo_q   <= lo_d;
      pc_q   <= pc_d;
      ir_q   <= ir_d;
      mar_q  <= mar_d;
      mdr_q  <= mdr_d;
      zhi_q  <= zhi_d;
      zlo_q  <= zlo_d;
      out_q  <= out_d;
      in_q   <= in_d;
      con_q  <= con_d;
    end
  end

  assign outport_data = out_q;
  assign ir_out       = ir_q;
  assign con_out      = con_q;
  assign bus_out      = bus;
endmodule

// File: tb/tb_bus_datapath.sv
// tb/tb_bus_datapath.sv - directed, table-driven bench for bus_datapath (WIDTH=32, PC_RESET=0x100)
module tb_bus_datapath;
  localparam int W = 32;

  logic         clock, clear;
  logic [3:0]   bus_src, reg_rsel, reg_wsel;
  logic         reg_we, y_in, hi_in, lo_in, mar_in, ir_in, out_in, mdr_in, pc_in, inc_pc;
  logic         z_in, con_in, alu_start, alu_busy, alu_done, mem_read, mem_write;
  logic [4:0]   alu_op;
  logic [W-1:0] inport_data, outport_data, ir_out, bus_out;
  logic         inport_strobe, con_out;

  bus_datapath_if #(.WIDTH(W), .AW(9)) mem_if ();

  bus_datapath #(.WIDTH(W), .NREGS(16), .PC_RESET(32'h100), .AW(9)) dut (
    .clock(clock), .clear(clear), .bus_src(bus_src), .reg_rsel(reg_rsel), .reg_wsel(reg_wsel),
    .reg_we(reg_we), .y_in(y_in), .hi_in(hi_in), .lo_in(lo_in), .mar_in(mar_in), .ir_in(ir_in),
    .out_in(out_in), .mdr_in(mdr_in), .pc_in(pc_in), .inc_pc(inc_pc), .z_in(z_in),
    .con_in(con_in), .alu_op(alu_op), .alu_start(alu_start), .alu_busy(alu_busy),
    .alu_done(alu_done), .mem_read(mem_read), .mem_write(mem_write), .mem(mem_if),
    .inport_data(inport_data), .inport_strobe(inport_strobe), .outport_data(outport_data),
    .ir_out(ir_out), .con_out(con_out), .bus_out(bus_out)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [4:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] exp;
  } vec_t;
  vec_t vecs [15];

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic put_bus(input logic [W-1:0] v);
    inport_data   = v;
    inport_strobe = 1'b1;
    tick();
    inport_strobe = 1'b0;
    bus_src       = 4'd7;
  endtask

  task automatic read_bus(input logic [3:0] src, output logic [W-1:0] v);
    bus_src = src;
    #1;
    v = bus_out;
  endtask

`ifdef BUS_DATAPATH_MULDIV_EN
  task automatic run_div(input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] q, input logic [W-1:0] r, input string tag);
    logic [W-1:0] v;
    int n;
    put_bus(a);
    y_in = 1'b1; tick(); y_in = 1'b0;
    put_bus(b);
    alu_op = 5'd12; alu_start = 1'b1; tick(); alu_start = 1'b0;
    n = 0;
    while (!alu_done && n < 100) begin
      tick();
      n++;
    end
    check({tag, "_done"}, W'(alu_done), 32'd1);
    read_bus(4'd4, v); check({tag, "_zlo"}, v, q);
    read_bus(4'd3, v); check({tag, "_zhi"}, v, r);
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] v;
    int edges;
    logic got;

    vecs[0]  = '{5'd0,  32'd5,         32'd7,         32'd12};
    vecs[1]  = '{5'd1,  32'd7,         32'hFFFF_FFFD, 32'd10};
    vecs[2]  = '{5'd2,  32'hF0F0_1234, 32'h0FF0_FFFF, 32'h00F0_1234};
    vecs[3]  = '{5'd3,  32'hF000_0000, 32'h0000_000F, 32'hF000_000F};
    vecs[4]  = '{5'd4,  32'h8000_0000, 32'd4,         32'h0800_0000};
    vecs[5]  = '{5'd5,  32'h8000_0000, 32'd4,         32'hF800_0000};
    vecs[6]  = '{5'd6,  32'h0000_0001, 32'd31,        32'h8000_0000};
    vecs[7]  = '{5'd7,  32'h0000_0001, 32'd1,         32'h8000_0000};
    vecs[8]  = '{5'd8,  32'h8000_0001, 32'd4,         32'h0000_0018};
    vecs[9]  = '{5'd4,  32'h0000_0100, 32'h24,        32'h0000_0010};
    vecs[10] = '{5'd7,  32'h1234_5678, 32'd0,         32'h1234_5678};
    vecs[11] = '{5'd9,  32'd0,         32'd5,         32'hFFFF_FFFB};
    vecs[12] = '{5'd10, 32'd0,         32'h0000_FFFF, 32'hFFFF_0000};
    vecs[13] = '{5'd13, 32'd3,         32'd4,         32'd0};
    vecs[14] = '{5'd31, 32'd3,         32'd4,         32'd0};

    clear = 1'b1; bus_src = '0; reg_rsel = '0; reg_wsel = '0; reg_we = 1'b0;
    y_in = 1'b0; hi_in = 1'b0; lo_in = 1'b0; mar_in = 1'b0; ir_in = 1'b0; out_in = 1'b0;
    mdr_in = 1'b0; pc_in = 1'b0; inc_pc = 1'b0; z_in = 1'b0; con_in = 1'b0;
    alu_op = '0; alu_start = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
    inport_data = '0; inport_strobe = 1'b0;
    mem_if.mem_rdata = '0; mem_if.mem_ack = 1'b0;
    repeat (2) @(posedge clock);
    #1 clear = 1'b0;

    read_bus(4'd2, v); check("reset_pc", v, 32'h100);
    read_bus(4'd4, v); check("reset_zlo", v, 32'd0);
    read_bus(4'd1, v); check("reset_mdr", v, 32'd0);
    check("reset_ir", ir_out, 32'd0);
    check("reset_outport", outport_data, 32'd0);
    check("reset_con", W'(con_out), 32'd0);
    check("reset_busy", W'(alu_busy), 32'd0);
    check("reset_done", W'(alu_done), 32'd0);
    check("reset_req", W'(mem_if.mem_req), 32'd0);
    check("reset_we", W'(mem_if.mem_we), 32'd0);
    check("reset_addr", W'(mem_if.mem_addr), 32'd0);

    inc_pc = 1'b1; repeat (3) tick(); inc_pc = 1'b0;
    read_bus(4'd2, v); check("pc_inc3", v, 32'h10C);
    put_bus(32'h200);
    pc_in = 1'b1; inc_pc = 1'b1; tick(); pc_in = 1'b0; inc_pc = 1'b0;
    read_bus(4'd2, v); check("pc_in_wins", v, 32'h200);
    read_bus(4'd9, v); check("bus_src9_zero", v, 32'd0);

    put_bus(32'd7);
    reg_wsel = 4'd3; reg_we = 1'b1; tick(); reg_we = 1'b0;
    put_bus(32'hFFFF_FFFD);
    reg_wsel = 4'd5; reg_we = 1'b1; tick(); reg_we = 1'b0;
    bus_src = 4'd0; reg_rsel = 4'd3; y_in = 1'b1; tick(); y_in = 1'b0;
    reg_rsel = 4'd5; #1; check("reg5_read", bus_out, 32'hFFFF_FFFD);
    alu_op = 5'd1; z_in = 1'b1; tick(); z_in = 1'b0;
    read_bus(4'd4, v); check("reg_sub_zlo", v, 32'd10);
    read_bus(4'd3, v); check("reg_sub_zhi", v, 32'd0);

    put_bus(32'h1234); hi_in = 1'b1; tick(); hi_in = 1'b0;
    put_bus(32'h5678); lo_in = 1'b1; out_in = 1'b1; tick(); lo_in = 1'b0; out_in = 1'b0;
    read_bus(4'd5, v); check("hi_load", v, 32'h1234);
    read_bus(4'd6, v); check("lo_load", v, 32'h5678);
    check("outport_load", outport_data, 32'h5678);

    for (int i = 0; i < 15; i++) begin
      put_bus(vecs[i].a);
      y_in = 1'b1; tick(); y_in = 1'b0;
      put_bus(vecs[i].b);
      alu_op = vecs[i].op; z_in = 1'b1; tick(); z_in = 1'b0;
      read_bus(4'd4, v); check($sformatf("alu_vec%0d_zlo", i), v, vecs[i].exp);
      read_bus(4'd3, v); check($sformatf("alu_vec%0d_zhi", i), v, 32'd0);
    end

    put_bus(32'hFFFF_FFFA);
    y_in = 1'b1; tick(); y_in = 1'b0;
    put_bus(32'd7);
    alu_op = 5'd10; z_in = 1'b1; tick(); z_in = 1'b0;
`ifdef BUS_DATAPATH_MULDIV_EN
    alu_op = 5'd11; alu_start = 1'b1; tick(); alu_start = 1'b0;
    edges = 1; got = 1'b0;
    check("mul_busy_rise", W'(alu_busy), 32'd1);
    while (!got && edges < 100) begin
      if (edges == 3) begin
        alu_start = 1'b1; alu_op = 5'd12;
      end else if (edges == 4) begin
        alu_start = 1'b0; z_in = 1'b1; alu_op = 5'd0;
      end else begin
        z_in = 1'b0;
      end
      tick();
      edges++;
      if (edges == 6) begin
        read_bus(4'd4, v); check("mul_z_held", v, 32'hFFFF_FFF8);
        check("mul_busy_mid", W'(alu_busy), 32'd1);
        bus_src = 4'd7;
      end
      if (alu_done) got = 1'b1;
    end
    check("mul_latency_edges", W'(edges), 32'd33);
    check("mul_busy_low_done", W'(alu_busy), 32'd0);
    read_bus(4'd4, v); check("mul_zlo", v, 32'hFFFF_FFD6);
    read_bus(4'd3, v); check("mul_zhi", v, 32'hFFFF_FFFF);
    tick();
    check("mul_done_pulse", W'(alu_done), 32'd0);
    alu_op = 5'd0; alu_start = 1'b1; tick(); alu_start = 1'b0;
    check("start_bad_op_ignored", W'(alu_busy), 32'd0);
    run_div(32'd17, 32'hFFFF_FFFB, 32'hFFFF_FFFD, 32'd2, "div_17_m5");
    run_div(32'd9, 32'd0, 32'hFFFF_FFFF, 32'd9, "div_by_zero");
`else
    alu_op = 5'd11; alu_start = 1'b1; tick(); alu_start = 1'b0;
    check("nomd_mul_done", W'(alu_done), 32'd1);
    check("nomd_mul_busy", W'(alu_busy), 32'd0);
    read_bus(4'd4, v); check("nomd_mul_zlo", v, 32'd0);
    read_bus(4'd3, v); check("nomd_mul_zhi", v, 32'd0);
    tick();
    check("nomd_done_pulse", W'(alu_done), 32'd0);
    put_bus(32'd7);
    alu_op = 5'd10; z_in = 1'b1; tick(); z_in = 1'b0;
    alu_op = 5'd12; alu_start = 1'b1; tick(); alu_start = 1'b0;
    check("nomd_div_done", W'(alu_done), 32'd1);
    read_bus(4'd4, v); check("nomd_div_zlo", v, 32'd0);
    alu_op = 5'd0; alu_start = 1'b1; tick(); alu_start = 1'b0;
    check("nomd_bad_op_ignored", W'(alu_done), 32'd0);
    edges = 0; got = 1'b0;
    check("nomd_counters", W'({got, edges[0]}), 32'd0);
`endif

    put_bus(32'h1F3); mar_in = 1'b1; tick(); mar_in = 1'b0;
    check("mem_addr", W'(mem_if.mem_addr), 32'h1F3);
    put_bus(32'hAAAA_5555); mdr_in = 1'b1; tick(); mdr_in = 1'b0;
    check("mem_wdata_mdr", mem_if.mem_wdata, 32'hAAAA_5555);
    mem_read = 1'b1; tick(); mem_read = 1'b0;
    check("rd_req_rise", W'(mem_if.mem_req), 32'd1);
    check("rd_we_low", W'(mem_if.mem_we), 32'd0);
    tick();
    check("rd_req_hold1", W'(mem_if.mem_req), 32'd1);
    put_bus(32'h1234_5678);
    check("rd_req_hold2", W'(mem_if.mem_req), 32'd1);
    check("rd_addr_hold", W'(mem_if.mem_addr), 32'h1F3);
    mem_if.mem_rdata = 32'hDEAD_BEEF; mem_if.mem_ack = 1'b1; mdr_in = 1'b1;
    tick();
    mem_if.mem_ack = 1'b0; mdr_in = 1'b0;
    check("rd_req_drop", W'(mem_if.mem_req), 32'd0);
    check("rd_mdr_wins", mem_if.mem_wdata, 32'hDEAD_BEEF);

    mem_write = 1'b1; tick(); mem_write = 1'b0;
    check("wr_req", W'(mem_if.mem_req), 32'd1);
    check("wr_we", W'(mem_if.mem_we), 32'd1);
    mem_if.mem_rdata = 32'h0BAD_F00D; mem_if.mem_ack = 1'b1; tick(); mem_if.mem_ack = 1'b0;
    check("wr_req_drop", W'(mem_if.mem_req), 32'd0);
    check("wr_mdr_kept", mem_if.mem_wdata, 32'hDEAD_BEEF);

    mem_read = 1'b1; mem_write = 1'b1; tick(); mem_read = 1'b0; mem_write = 1'b0;
    check("rw_read_taken", W'(mem_if.mem_we), 32'd0);
    mem_write = 1'b1; tick(); mem_write = 1'b0;
    check("wait_req_ignored", W'(mem_if.mem_we), 32'd0);
    mem_if.mem_rdata = 32'h600D_CAFE; mem_if.mem_ack = 1'b1; tick(); mem_if.mem_ack = 1'b0;
    check("rw_mdr", mem_if.mem_wdata, 32'h600D_CAFE);
    tick();
    check("rw_no_followup", W'(mem_if.mem_req), 32'd0);

    put_bus(32'h0018_0000); ir_in = 1'b1; tick(); ir_in = 1'b0;
    check("ir_load", ir_out, 32'h0018_0000);
    put_bus(32'h8000_0000); con_in = 1'b1; tick(); con_in = 1'b0;
    check("con_msb1", W'(con_out), 32'd1);
    put_bus(32'h0); ir_in = 1'b1; tick(); ir_in = 1'b0;
    put_bus(32'h8000_0000); con_in = 1'b1; tick(); con_in = 1'b0;
    check("con_eq0", W'(con_out), 32'd0);
    put_bus(32'h0008_0000); ir_in = 1'b1; tick(); ir_in = 1'b0;
    put_bus(32'h8000_0000); con_in = 1'b1; tick(); con_in = 1'b0;
    check("con_ne0", W'(con_out), 32'd1);
    put_bus(32'h0010_0000); ir_in = 1'b1; tick(); ir_in = 1'b0;
    put_bus(32'h8000_0000); con_in = 1'b1; tick(); con_in = 1'b0;
    check("con_msb0", W'(con_out), 32'd0);
    put_bus(32'h0004_0000); ir_in = 1'b1; tick(); ir_in = 1'b0;
    read_bus(4'd8, v); check("c_sign_neg", v, 32'hFFFC_0000);
    put_bus(32'hFFF1_2345); ir_in = 1'b1; tick(); ir_in = 1'b0;
    read_bus(4'd8, v); check("c_sign_pos", v, 32'h0001_2345);

    mem_read = 1'b1; tick(); mem_read = 1'b0;
    check("clr_req_before", W'(mem_if.mem_req), 32'd1);
    #2 clear = 1'b1;
    #1;
    check("clr_req_async", W'(mem_if.mem_req), 32'd0);
    check("clr_mdr", mem_if.mem_wdata, 32'd0);
    @(posedge clock);
    #1 clear = 1'b0;
    read_bus(4'd2, v); check("clr_pc", v, 32'h100);
    read_bus(4'd4, v); check("clr_zlo", v, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
